// File: rtl/systolic_array_MAC_if.sv
// Signal bundle between one systolic-array PE and its neighbours: operand inputs,
// activation forwarding and the accumulate result.
interface systolic_array_MAC_if;
  logic        start;
  logic        MAC_shift;
  logic [15:0] in_value;
  logic [15:0] weight;
  logic [15:0] in_accumulate;
  logic [15:0] out_value;
  logic [15:0] out_accumulate;
  logic        value_ready;

  modport MAC (
    input  start, MAC_shift, in_value, weight, in_accumulate,
    output out_value, out_accumulate, value_ready
  );

  modport tb (
    output start, MAC_shift, in_value, weight, in_accumulate,
    input  out_value, out_accumulate, value_ready
  );
endinterface

// File: rtl/sysarr_mac_unit.sv
// Systolic-array PE: binary16 out_accumulate = in_value * weight + in_accumulate,
// computed over a fixed four-stage sequence (MUL, ALIGN, ADD, NORM) after start.
module sysarr_mac_unit (
  input logic               clk,
  input logic               nRST,
  systolic_array_MAC_if.MAC mac_if
);
  typedef enum logic [2:0] {IDLE, MUL, ALIGN, ADD, NORM} state_t;

  localparam logic [15:0] QNAN = 16'h7E00;

  state_t state_q, state_d;

  // Captured operands and the snapshot used by the running operation
  logic [15:0] val_q, val_d, wgt_q, wgt_d, acc_q, acc_d;
  logic [15:0] val_w_q, val_w_d, wgt_w_q, wgt_w_d, acc_w_q, acc_w_d;
  logic [15:0] out_value_q, out_value_d;

  // MUL stage results; significands are fixed point with 20 fraction bits
  logic [21:0]       prod_sig_q, prod_sig_d, addend_sig_q, addend_sig_d;
  logic signed [9:0] prod_exp_q, prod_exp_d, addend_exp_q, addend_exp_d;
  logic              prod_sign_q, prod_sign_d, addend_sign_q, addend_sign_d;
  logic              prod_zero_q, prod_zero_d, addend_zero_q, addend_zero_d;
  logic              spec_q, spec_d;
  logic [15:0]       spec_res_q, spec_res_d;

  // ALIGN stage results; three extra low bits hold guard, round and sticky
  logic [24:0]       big_q, big_d, small_q, small_d;
  logic              big_sign_q, big_sign_d, eff_sub_q, eff_sub_d;
  logic signed [9:0] exp_q, exp_d;

  // ADD stage results
  logic [25:0] mag_q, mag_d;
  logic        sum_sign_q, sum_sign_d;

  logic [15:0] out_acc_q, out_acc_d;
  logic        ready_q, ready_d;

  // Operand unpack: index 0 = activation, 1 = weight, 2 = addend
  logic [15:0] op_w [3];
  logic [2:0]  op_sign, op_zero, op_inf, op_nan;
  logic [4:0]  op_exp [3];
  logic [9:0]  op_frac [3];

  assign op_w[0] = val_w_q;
  assign op_w[1] = wgt_w_q;
  assign op_w[2] = acc_w_q;

  for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
    assign op_sign[gi] = op_w[gi][15];
    assign op_exp[gi]  = op_w[gi][14:10];
    assign op_frac[gi] = op_w[gi][9:0];
    assign op_zero[gi] = (op_exp[gi] == 5'd0);
    assign op_inf[gi]  = (op_exp[gi] == 5'h1F) && (op_frac[gi] == 10'd0);
    assign op_nan[gi]  = (op_exp[gi] == 5'h1F) && (op_frac[gi] != 10'd0);
  end

  logic [10:0] sig_a, sig_b;
  logic [21:0] prod_full;
  logic        prod_inf, prod_sign, prod_zero;

  assign sig_a     = {1'b1, op_frac[0]};
  assign sig_b     = {1'b1, op_frac[1]};
  assign prod_full = sig_a * sig_b;
  assign prod_inf  = op_inf[0] | op_inf[1];
  assign prod_sign = op_sign[0] ^ op_sign[1];
  assign prod_zero = op_zero[0] | op_zero[1];

  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    wgt_d       = wgt_q;
    acc_d       = acc_q;
    out_value_d = out_value_q;
    val_w_d     = val_w_q;
    wgt_w_d     = wgt_w_q;
    acc_w_d     = acc_w_q;
    if (mac_if.MAC_shift) begin
      val_d       = mac_if.in_value;
      wgt_d       = mac_if.weight;
      acc_d       = mac_if.in_accumulate;
      out_value_d = mac_if.in_value;
    end
    case (state_q)
      IDLE: begin
        if (mac_if.start) begin
          state_d = MUL;
          val_w_d = val_q;
          wgt_w_d = wgt_q;
          acc_w_d = acc_q;
        end
      end
      MUL:     state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod_sig_d    = prod_sig_q;
    prod_exp_d    = prod_exp_q;
    prod_sign_d   = prod_sign_q;
    prod_zero_d   = prod_zero_q;
    addend_sig_d  = addend_sig_q;
    addend_exp_d  = addend_exp_q;
    addend_sign_d = addend_sign_q;
    addend_zero_d = addend_zero_q;
    spec_d        = spec_q;
    spec_res_d    = spec_res_q;
    if (state_q == MUL) begin
      prod_zero_d   = prod_zero;
      prod_sign_d   = prod_sign;
      prod_sig_d    = prod_zero ? 22'd0 : prod_full;
      prod_exp_d    = $signed({5'd0, op_exp[0]}) + $signed({5'd0, op_exp[1]}) - 10'sd15;
      addend_zero_d = op_zero[2];
      addend_sign_d = op_sign[2];
      addend_sig_d  = op_zero[2] ? 22'd0 : {1'b0, 1'b1, op_frac[2], 10'd0};
      addend_exp_d  = $signed({5'd0, op_exp[2]});
      spec_d        = 1'b0;
      spec_res_d    = 16'd0;
      if ((|op_nan) || (prod_inf && prod_zero) ||
          (prod_inf && op_inf[2] && (prod_sign != op_sign[2]))) begin
        spec_d     = 1'b1;
        spec_res_d = QNAN;
      end else if (prod_inf) begin
        spec_d     = 1'b1;
        spec_res_d = {prod_sign, 5'h1F, 10'd0};
      end else if (op_inf[2]) begin
        spec_d     = 1'b1;
        spec_res_d = {op_sign[2], 5'h1F, 10'd0};
      end
    end
  end

  logic              prod_big;
  logic [24:0]       small_raw;
  logic signed [9:0] exp_diff;
  logic [4:0]        shamt;
  logic [50:0]       wide;

  always_comb begin
    big_d      = big_q;
    small_d    = small_q;
    big_sign_d = big_sign_q;
    eff_sub_d  = eff_sub_q;
    exp_d      = exp_q;
    // A zero operand never wins the exponent compare so the live one sets the scale
    prod_big   = addend_zero_q || (!prod_zero_q && (prod_exp_q >= addend_exp_q));
    if (prod_big) begin
      small_raw = {addend_sig_q, 3'b000};
      exp_diff  = prod_exp_q - addend_exp_q;
    end else begin
      small_raw = {prod_sig_q, 3'b000};
      exp_diff  = addend_exp_q - prod_exp_q;
    end
    if ((exp_diff > 10'sd26) || (exp_diff < 10'sd0)) begin
      shamt = 5'd26;
    end else begin
      shamt = exp_diff[4:0];
    end
    wide = {small_raw, 26'd0} >> shamt;
    if (state_q == ALIGN) begin
      big_d      = prod_big ? {prod_sig_q, 3'b000} : {addend_sig_q, 3'b000};
      big_sign_d = prod_big ? prod_sign_q : addend_sign_q;
      exp_d      = prod_big ? prod_exp_q : addend_exp_q;
      small_d    = {wide[50:27], wide[26] | (|wide[25:0])};
      eff_sub_d  = prod_sign_q ^ addend_sign_q;
    end
  end

  always_comb begin
    mag_d      = mag_q;
    sum_sign_d = sum_sign_q;
    if (state_q == ADD) begin
      sum_sign_d = big_sign_q;
      if (!eff_sub_q) begin
        mag_d = {1'b0, big_q} + {1'b0, small_q};
      end else if (big_q < small_q) begin
        mag_d      = {1'b0, small_q} - {1'b0, big_q};
        sum_sign_d = ~big_sign_q;
      end else begin
        mag_d = {1'b0, big_q} - {1'b0, small_q};
      end
    end
  end

  logic [4:0]        lead;
  logic [24:0]       norm;
  logic              rnd_up;
  logic [10:0]       frac_rnd;
  logic signed [9:0] res_exp, res_exp_rnd;
  logic [15:0]       result;

  always_comb begin
    lead = 5'd0;
    for (int i = 0; i < 26; i++) begin
      if (mag_q[i]) lead = 5'(i);
    end
    // Leading one moves to bit 25 and drops out as the hidden bit
    norm        = 25'(mag_q << (5'd25 - lead));
    rnd_up      = norm[14] & ((|norm[13:0]) | norm[15]);
    frac_rnd    = {1'b0, norm[24:15]} + {10'd0, rnd_up};
    res_exp     = exp_q + $signed({5'd0, lead}) - 10'sd23;
    res_exp_rnd = res_exp + $signed({9'd0, frac_rnd[10]});
    if (spec_q) begin
      result = spec_res_q;
    end else if (mag_q == 26'd0) begin
      result = 16'h0000;
    end else if (res_exp_rnd >= 10'sd31) begin
      result = {sum_sign_q, 5'h1F, 10'd0};
    end else if (res_exp_rnd <= 10'sd0) begin
      result = 16'h0000;
    end else begin
      result = {sum_sign_q, res_exp_rnd[4:0], frac_rnd[9:0]};
    end
    out_acc_d = out_acc_q;
    ready_d   = 1'b0;
    if (state_q == NORM) begin
      out_acc_d = result;
      ready_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q       <= IDLE;
      val_q         <= '0;
      wgt_q         <= '0;
      acc_q         <= '0;
      val_w_q       <= '0;
      wgt_w_q       <= '0;
      acc_w_q       <= '0;
      out_value_q   <= '0;
      prod_sig_q    <= '0;
      prod_exp_q    <= '0;
      prod_sign_q   <= 1'b0;
      prod_zero_q   <= 1'b0;
      addend_sig_q  <= '0;
      addend_exp_q  <= '0;
      addend_sign_q <= 1'b0;
      addend_zero_q <= 1'b0;
      spec_q        <= 1'b0;
      spec_res_q    <= '0;
      big_q         <= '0;
      small_q       <= '0;
      big_sign_q    <= 1'b0;
      eff_sub_q     <= 1'b0;
      exp_q         <= '0;
      mag_q         <= '0;
      sum_sign_q    <= 1'b0;
      out_acc_q     <= '0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      val_q         <= val_d;
      wgt_q         <= wgt_d;
      acc_q         <= acc_d;
      val_w_q       <= val_w_d;
      wgt_w_q       <= wgt_w_d;
      acc_w_q       <= acc_w_d;
      out_value_q   <= out_value_d;
      prod_sig_q    <= prod_sig_d;
      prod_exp_q    <= prod_exp_d;
      prod_sign_q   <= prod_sign_d;
      prod_zero_q   <= prod_zero_d;
      addend_sig_q  <= addend_sig_d;
      addend_exp_q  <= addend_exp_d;
      addend_sign_q <= addend_sign_d;
      addend_zero_q <= addend_zero_d;
      spec_q        <= spec_d;
      spec_res_q    <= spec_res_d;
      big_q         <= big_d;
      small_q       <= small_d;
      big_sign_q    <= big_sign_d;
      eff_sub_q     <= eff_sub_d;
      exp_q         <= exp_d;
      mag_q         <= mag_d;
      sum_sign_q    <= sum_sign_d;
      out_acc_q     <= out_acc_d;
      ready_q       <= ready_d;
    end
  end

  assign mac_if.out_value      = out_value_q;
  assign mac_if.out_accumulate = out_acc_q;
  assign mac_if.value_ready    = ready_q;
endmodule

// File: tb/tb_sysarr_mac_unit.sv
// Directed bench for the binary16 MAC PE: arithmetic vectors, latency and protocol corners.
module tb_sysarr_mac_unit;
  logic clk = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] last_res = 16'h0000;

  systolic_array_MAC_if mac_if ();

  sysarr_mac_unit dut (
    .clk    (clk),
    .nRST   (nRST),
    .mac_if (mac_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic shift_ops(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    mac_if.in_value      = a;
    mac_if.weight        = b;
    mac_if.in_accumulate = c;
    mac_if.MAC_shift     = 1'b1;
    @(negedge clk);
    mac_if.MAC_shift     = 1'b0;
  endtask

  // Called at a negedge with ready low; returns negedges until ready is seen
  task automatic wait_ready(output int lat);
    lat = 0;
    while (mac_if.value_ready !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_start(input string tag, input logic [15:0] expv);
    int lat;
    mac_if.start = 1'b1;
    @(negedge clk);
    mac_if.start = 1'b0;
    check({tag, "/hold"}, 32'(mac_if.out_accumulate), 32'(last_res));
    wait_ready(lat);
    check({tag, "/latency"}, 32'(lat), 32'd4);
    check({tag, "/result"}, 32'(mac_if.out_accumulate), 32'(expv));
    $display("%s: result %h expected %h latency %0d", tag, mac_if.out_accumulate, expv, lat);
    @(negedge clk);
    check({tag, "/pulse_end"}, 32'(mac_if.value_ready), 32'd0);
    last_res = expv;
  endtask

  task automatic do_mac(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] expv);
    shift_ops(a, b, c);
    check({tag, "/out_value"}, 32'(mac_if.out_value), 32'(a));
    run_start(tag, expv);
  endtask

  initial begin
    int lat;
    int pulses;
    int first;
    nRST                 = 1'b0;
    mac_if.start         = 1'b0;
    mac_if.MAC_shift     = 1'b0;
    mac_if.in_value      = 16'h0;
    mac_if.weight        = 16'h0;
    mac_if.in_accumulate = 16'h0;
    @(negedge clk);
    check("reset/out_value", 32'(mac_if.out_value), 32'd0);
    check("reset/out_accumulate", 32'(mac_if.out_accumulate), 32'd0);
    check("reset/value_ready", 32'(mac_if.value_ready), 32'd0);
    $display("reset: out_value %h out_accumulate %h ready %b",
             mac_if.out_value, mac_if.out_accumulate, mac_if.value_ready);
    nRST = 1'b1;
    @(negedge clk);

    do_mac("basic",      16'h4000, 16'h4700, 16'h4500, 16'h4CC0);
    do_mac("cancel",     16'h3C00, 16'h3C00, 16'hBC00, 16'h0000);
    do_mac("zero_prod",  16'h0000, 16'h0000, 16'h4CC0, 16'h4CC0);
    do_mac("rne_small",  16'h3C01, 16'h3C01, 16'h0000, 16'h3C02);
    do_mac("round_up",   16'h3E01, 16'h3E01, 16'h0000, 16'h4082);
    do_mac("tie_odd",    16'h3C01, 16'h3E00, 16'h0000, 16'h3E02);
    do_mac("tie_even",   16'h3C03, 16'h3E00, 16'h0000, 16'h3E04);
    do_mac("overflow",   16'h7BFF, 16'h4000, 16'h0000, 16'h7C00);
    do_mac("nan_in",     16'h7E00, 16'h3C00, 16'h0000, 16'h7E00);
    do_mac("inf_x_zero", 16'h7C00, 16'h0000, 16'h0000, 16'h7E00);
    do_mac("inf_m_inf",  16'h7C00, 16'h3C00, 16'hFC00, 16'h7E00);
    do_mac("inf_finite", 16'h7C00, 16'h3C00, 16'hC000, 16'h7C00);
    do_mac("neg_result", 16'hC000, 16'h4200, 16'h4400, 16'hC000);
    do_mac("sign_flip",  16'h3C00, 16'h3C00, 16'hBE00, 16'hB800);
    do_mac("sub_input",  16'h0001, 16'h3C00, 16'h3C00, 16'h3C00);
    do_mac("underflow",  16'h0400, 16'h3800, 16'h0000, 16'h0000);
    do_mac("neg_zero",   16'h8000, 16'h3C00, 16'h8000, 16'h0000);
    do_mac("zero_p_neg", 16'h0000, 16'h3C00, 16'hC000, 16'hC000);

    // Second start two cycles into an operation must be ignored
    shift_ops(16'h4000, 16'h4700, 16'h4500);
    mac_if.start = 1'b1;
    @(negedge clk);
    mac_if.start = 1'b0;
    @(negedge clk);
    mac_if.start = 1'b1;
    @(negedge clk);
    mac_if.start = 1'b0;
    pulses = 0;
    first  = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mac_if.value_ready === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("restart/pulses", 32'(pulses), 32'd1);
    check("restart/when", 32'(first), 32'd2);
    check("restart/result", 32'(mac_if.out_accumulate), 32'h4CC0);
    $display("restart: pulses %0d result %h", pulses, mac_if.out_accumulate);
    last_res = 16'h4CC0;

    // New operands shifted in while busy do not disturb the running operation
    shift_ops(16'h3C00, 16'h4000, 16'h3C00);
    mac_if.start = 1'b1;
    @(negedge clk);
    mac_if.start = 1'b0;
    shift_ops(16'h4000, 16'h4700, 16'h4500);
    check("busy_shift/out_value", 32'(mac_if.out_value), 32'h4000);
    wait_ready(lat);
    check("busy_shift/latency", 32'(lat), 32'd3);
    check("busy_shift/result", 32'(mac_if.out_accumulate), 32'h4200);
    $display("busy_shift: result %h latency %0d", mac_if.out_accumulate, lat + 1);
    @(negedge clk);
    last_res = 16'h4200;
    run_start("busy_shift_next", 16'h4CC0);

    // start and MAC_shift on the same edge: operation uses the older operands
    shift_ops(16'h3C00, 16'h3C00, 16'h3C00);
    mac_if.in_value      = 16'h4000;
    mac_if.weight        = 16'h4000;
    mac_if.in_accumulate = 16'h0000;
    mac_if.MAC_shift     = 1'b1;
    mac_if.start         = 1'b1;
    @(negedge clk);
    mac_if.MAC_shift     = 1'b0;
    mac_if.start         = 1'b0;
    wait_ready(lat);
    check("same_edge/result", 32'(mac_if.out_accumulate), 32'h4000);
    $display("same_edge: result %h", mac_if.out_accumulate);
    @(negedge clk);
    last_res = 16'h4000;
    run_start("same_edge_next", 16'h4400);

    // Reset at edge N+2 aborts the operation and clears everything
    shift_ops(16'h4000, 16'h4700, 16'h4500);
    mac_if.start = 1'b1;
    @(negedge clk);
    mac_if.start = 1'b0;
    @(negedge clk);
    nRST = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
    check("abort/out_value", 32'(mac_if.out_value), 32'd0);
    check("abort/out_accumulate", 32'(mac_if.out_accumulate), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (mac_if.value_ready === 1'b1) pulses++;
      @(negedge clk);
    end
    check("abort/pulses", 32'(pulses), 32'd0);
    $display("abort: out_value %h out_accumulate %h pulses %0d",
             mac_if.out_value, mac_if.out_accumulate, pulses);
    last_res = 16'h0000;
    run_start("after_abort", 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
